// File: rtl/calc_seq_core.sv
// Stage-sequenced calculator core: NUM1 -> NUM2 -> OP -> CALC -> SHOW, iterative mul/div.
// Define CALC_BTN_SYNC_EN to pass both buttons through 2-flop synchronisers before edge detection.
module calc_seq_core #(
    parameter int unsigned W     = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           btn_next,
    input  logic           btn_prev,
    input  logic [W-1:0]   sw,
    output logic [W-1:0]   num1,
    output logic [W-1:0]   num2,
    output logic [2:0]     opcode,
    output logic [2*W-1:0] answer,
    output logic           is_negative,
    output logic           div_zero,
    output logic           busy,
    output logic           store_num1,
    output logic           store_num2,
    output logic           store_op,
    output logic           show_answer
);
    localparam logic [2:0] StNum1 = 3'd0;
    localparam logic [2:0] StNum2 = 3'd1;
    localparam logic [2:0] StOp   = 3'd2;
    localparam logic [2:0] StCalc = 3'd3;
    localparam logic [2:0] StShow = 3'd4;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpMul = 3'b010;
    localparam logic [2:0] OpDiv = 3'b011;
    localparam logic [2:0] OpMod = 3'b100;
    localparam logic [2:0] OpAnd = 3'b101;
    localparam logic [2:0] OpOr  = 3'b110;

    logic next_lvl, prev_lvl;

`ifdef CALC_BTN_SYNC_EN
    // Presses stay masked until the synchroniser and edge register hold real levels.
    localparam logic [1:0] SettleCycles = 2'd3;
    logic [1:0] next_sync_q, prev_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_sync_q <= '0;
            prev_sync_q <= '0;
        end else begin
            next_sync_q <= {next_sync_q[0], btn_next};
            prev_sync_q <= {prev_sync_q[0], btn_prev};
        end
    end

    assign next_lvl = next_sync_q[1];
    assign prev_lvl = prev_sync_q[1];
`else
    localparam logic [1:0] SettleCycles = 2'd1;
    assign next_lvl = btn_next;
    assign prev_lvl = btn_prev;
`endif

    logic [2:0]       stage_q, stage_d;
    logic [W-1:0]     num1_q, num1_d, num2_q, num2_d, aux_q, aux_d;
    logic [2:0]       op_q, op_d;
    logic [2*W-1:0]   answer_q, answer_d, acc_q, acc_d;
    logic             neg_q, neg_d, dz_q, dz_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             next_last_q, prev_last_q;
    logic [1:0]       settle_q;
    logic             armed, press_next, press_prev;

    assign armed      = (settle_q == SettleCycles);
    assign press_next = armed & next_lvl & ~next_last_q;
    assign press_prev = armed & prev_lvl & ~prev_last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_last_q <= 1'b0;
            prev_last_q <= 1'b0;
            settle_q    <= '0;
        end else begin
            next_last_q <= next_lvl;
            prev_last_q <= prev_lvl;
            if (!armed) settle_q <= settle_q + 2'd1;
        end
    end

    // Iterative datapath: acc holds the product, or the partial remainder in its low W+1 bits.
    logic [W:0]     trial, trial_diff, rem_next;
    logic           q_bit;
    logic [W-1:0]   quot_next;
    logic [2*W-1:0] prod_next, n1_ext, n2_ext, single_ans;
    logic           single_neg, is_iter, last_iter;

    assign n1_ext     = {{W{1'b0}}, num1_q};
    assign n2_ext     = {{W{1'b0}}, num2_q};
    assign trial      = {acc_q[W-1:0], aux_q[W-1]};
    assign q_bit      = (trial >= {1'b0, num2_q});
    assign trial_diff = trial - {1'b0, num2_q};
    assign rem_next   = q_bit ? trial_diff : trial;
    assign quot_next  = {aux_q[W-2:0], q_bit};
    assign prod_next  = (acc_q << 1) + (aux_q[W-1] ? n1_ext : '0);
    assign is_iter    = (op_q == OpMul) ||
                        (((op_q == OpDiv) || (op_q == OpMod)) && (num2_q != '0));
    assign last_iter  = (cnt_q == CNT_W'(W - 1));

    always_comb begin
        single_ans = '0;
        single_neg = 1'b0;
        case (op_q)
            OpAdd: single_ans = n1_ext + n2_ext;
            OpSub: begin
                if (num1_q < num2_q) begin
                    single_ans = n2_ext - n1_ext;
                    single_neg = 1'b1;
                end else begin
                    single_ans = n1_ext - n2_ext;
                end
            end
            OpAnd:   single_ans = n1_ext & n2_ext;
            OpOr:    single_ans = n1_ext | n2_ext;
            3'b111:  single_ans = n1_ext ^ n2_ext;
            default: single_ans = '1; // divide or modulo by zero
        endcase
    end

    always_comb begin
        stage_d  = stage_q;
        num1_d   = num1_q;
        num2_d   = num2_q;
        op_d     = op_q;
        answer_d = answer_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        aux_d    = aux_q;
        case (stage_q)
            StNum1: begin
                if (press_next) begin
                    stage_d = StNum2;
                    num1_d  = sw;
                end
            end
            StNum2: begin
                if (press_next) begin
                    stage_d = StOp;
                    num2_d  = sw;
                end else if (press_prev) begin
                    stage_d = StNum1;
                end
            end
            StOp: begin
                if (press_next) begin
                    stage_d = StCalc;
                    op_d    = sw[2:0];
                    neg_d   = 1'b0;
                    dz_d    = 1'b0;
                    cnt_d   = '0;
                    acc_d   = '0;
                    aux_d   = (sw[2:0] == OpMul) ? num2_q : num1_q;
                end else if (press_prev) begin
                    stage_d = StNum2;
                end
            end
            StCalc: begin
                if (!is_iter) begin
                    stage_d  = StShow;
                    answer_d = single_ans;
                    neg_d    = single_neg;
                    dz_d     = (op_q == OpDiv) || (op_q == OpMod);
                end else begin
                    if (op_q == OpMul) begin
                        acc_d = prod_next;
                        aux_d = aux_q << 1;
                    end else begin
                        acc_d = {{(W-1){1'b0}}, rem_next};
                        aux_d = quot_next;
                    end
                    if (last_iter) begin
                        stage_d = StShow;
                        cnt_d   = '0;
                        unique case (op_q)
                            OpMul:   answer_d = prod_next;
                            OpDiv:   answer_d = {{W{1'b0}}, quot_next};
                            default: answer_d = {{W{1'b0}}, rem_next[W-1:0]};
                        endcase
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StShow: begin
                if (press_next) begin
                    stage_d = StNum1;
                end else if (press_prev) begin
                    stage_d = StOp;
                end
            end
            default: stage_d = StNum1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q  <= StNum1;
            num1_q   <= '0;
            num2_q   <= '0;
            op_q     <= '0;
            answer_q <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            aux_q    <= '0;
        end else begin
            stage_q  <= stage_d;
            num1_q   <= num1_d;
            num2_q   <= num2_d;
            op_q     <= op_d;
            answer_q <= answer_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            aux_q    <= aux_d;
        end
    end

    assign num1        = num1_q;
    assign num2        = num2_q;
    assign opcode      = op_q;
    assign answer      = answer_q;
    assign is_negative = neg_q;
    assign div_zero    = dz_q;
    assign busy        = (stage_q == StCalc);
    assign store_num1  = (stage_q == StNum1);
    assign store_num2  = (stage_q == StNum2);
    assign store_op    = (stage_q == StOp);
    assign show_answer = (stage_q == StShow);

endmodule

// File: doc/calc_seq_core.md
Name: calc_seq_core

Overview:
- Parametrised, sequential successor to the calculator datapath/stage logic.
- Merges stage selection, operand/opcode capture and arithmetic into one clocked block with an explicit compute phase.
- Multiply and divide are iterative (one bit per cycle), not combinational.
- Sits between the board-level button/switch inputs and the seven-segment/LED display logic.

Parameters:
- W, 16: operand width in bits; answer is 2*W bits.
- CNT_W, 5: width of iteration counter; must satisfy 2^CNT_W > W.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- btn_next  input  1  advance-stage button, level; rising edge acts
- btn_prev  input  1  previous-stage button, level; rising edge acts
- sw  input  W  operand switches; sw[2:0] is the opcode in the OP stage
- num1  output  W  latched operand 1
- num2  output  W  latched operand 2
- opcode  output  3  latched opcode
- answer  output  2*W  result, valid in SHOW
- is_negative  output  1  sub result was negative; answer holds magnitude
- div_zero  output  1  divide/modulo by zero
- busy  output  1  high in CALC
- store_num1 / store_num2 / store_op / show_answer  output  1 each  one-hot stage indicators

Behaviour:
- Edge detection:
  - Registered previous level per button; press = level & ~prev_level.
  - A press is consumed in the cycle it is detected.
  - Next and prev pressed in the same cycle: next wins.
- Stages and transitions:
  - NUM1: next -> NUM2 and latch sw into num1 that cycle; prev ignored.
  - NUM2: next -> OP and latch num2; prev -> NUM1, num2 unchanged.
  - OP: next -> CALC and latch sw[2:0] into opcode; prev -> NUM2.
  - CALC: both buttons ignored; -> SHOW when the operation completes.
  - SHOW: next -> NUM1, answer retained until next CALC; prev -> OP.
- Stage indicators:
  - store_num1, store_num2, store_op and show_answer are high in NUM1, NUM2, OP and SHOW respectively.
  - All four are low in CALC, where busy=1.
- Operations (unsigned operands, zero-extended to 2*W):
  - 000 add: 1 CALC cycle.
  - 001 sub: 1 CALC cycle. If num1<num2, answer=num2-num1 and is_negative=1; else answer=num1-num2 and is_negative=0.
  - 010 mul: shift-add, exactly W CALC cycles.
  - 011 div: restoring divider, exactly W CALC cycles; answer=quotient.
  - 100 mod: same divider, W cycles; answer=remainder.
  - 101 and / 110 or / 111 xor: bitwise, 1 CALC cycle.
- Divide-by-zero: opcode 011/100 with num2=0 -> 1 CALC cycle, answer=all ones, div_zero=1.
- Flags:
  - is_negative and div_zero are cleared on entry to CALC.
  - They are only set by the CALC cycle that produces answer.
- Answer timing:
  - answer is only written on the final CALC cycle.
  - Intermediate accumulator/remainder state is internal and never visible on answer.
- Reset (async assert, any stage including mid-CALC):
  - Stage=NUM1, all outputs 0 except store_num1=1.
  - Iteration counter 0; edge-detect registers cleared.
  - A button held through reset release does not count as a press.

Optional Feature:
- Macro: CALC_BTN_SYNC_EN
- Defined:
  - btn_next and btn_prev each pass through a 2-flop synchroniser (reset to 0) before edge detection.
  - Press-to-stage-change latency is 3 clk cycles.
- Undefined:
  - Inputs feed edge detection directly.
  - Latency is 1 cycle: the stage register updates on the edge after the press is sampled.
- Macro state does not affect computation timing.

Test Plan:
(W=8, no macro)
1. Enter num1=200, num2=100, op=010, press next; busy high exactly 8 cycles -> SHOW, answer=20000, is_negative=0.
2. num1=5, num2=9, op=001 -> 1 CALC cycle, answer=4, is_negative=1; then SHOW->NUM1->...->op=000 -> is_negative=0, answer=14.
3. num1=77, num2=0, op=011 -> 1 CALC cycle, answer=16'hFFFF, div_zero=1. Repeat with op=100 -> same result.
4. num1=250, num2=7, op=011 -> answer=35 after 8 cycles; op=100 -> answer=5.
5. Navigation:
   - prev in NUM2 -> NUM1 with num2 unchanged.
   - Next+prev in the same cycle -> advance.
   - Button held 20 cycles -> exactly one transition.
   - Presses during CALC -> ignored.
6. Assert rst on CALC cycle 4 of a multiply -> all outputs 0, store_num1=1 immediately. Release with btn_next held -> stays NUM1 until btn_next is released and pressed again.
